multicycle_control_fsm: RTL and testbench

//  Multi-cycle control sequencer for the MIPS core: replaces per-instruction combinational decode

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_control_fsm.sv | 159 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer, ALU decoder and datapath.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control word driven by the sequencer each cycle.
    typedef struct packed {
        logic             mem_req;
        logic             pc_write;
        logic             iord;
        logic             ir_write;
        logic             mem_write;
        logic             reg_write;
        logic             reg_dst;
        logic             memto_reg;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_src;
        logic             retire;
        logic             illegal_op;
    } ctrl_t;

    // State following DECODE; unsupported opcodes fall back to FETCH.
    function automatic state_t decode_next(input logic [OP_W-1:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECUTE;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps the shared ALU and unified memory through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RET_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             iord,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             memto_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic             illegal_op,
    output logic [RET_W-1:0] retired_cnt
);

    state_t state;
    logic   is_store;
    ctrl_t  ctrl;

    // State register with next-state logic; load/store direction captured in DECODE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            is_store <= 1'b0;
        end else begin
            case (state)
                S_FETCH:   if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    state    <= decode_next(opcode);
                    is_store <= (opcode == OP_SW);
                end
                S_MEMADR:  state <= is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state <= S_MEMWB;
                S_MEMWB:   state <= S_FETCH;
                S_MEMWR:   if (mem_ready) state <= S_FETCH;
                S_EXECUTE: state <= S_ALUWB;
                S_ALUWB:   state <= S_FETCH;
                S_BRANCH:  state <= S_FETCH;
                S_ADDIEX:  state <= S_ADDIWB;
                S_ADDIWB:  state <= S_FETCH;
                S_JUMP:    state <= S_FETCH;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Output decode from state; reset forces every control low immediately.
    always_comb begin
        ctrl = '0;
        if (reset_n) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_src    = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = SRCB_IMM_SH2;
                    ctrl.illegal_op = ~op_supported(opcode);
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.iord    = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.memto_reg = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = mem_ready;
                    ctrl.retire    = mem_ready;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = PCSRC_ALUOUT;
                    ctrl.pc_write  = zero;
                    ctrl.retire    = 1'b1;
                end
                S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_ADDIWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_src   = PCSRC_JUMP;
                    ctrl.pc_write = 1'b1;
                    ctrl.retire   = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_cnt <= '0;
        end else if (ctrl.retire) begin
            retired_cnt <= retired_cnt + RET_W'(1);
        end
    end

    assign mem_req    = ctrl.mem_req;
    assign pc_write   = ctrl.pc_write;
    assign iord       = ctrl.iord;
    assign ir_write   = ctrl.ir_write;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign memto_reg  = ctrl.memto_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign retire     = ctrl.retire;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven scoreboard bench for the multi-cycle control sequencer.
module tb_multicycle_control_fsm;

    localparam int unsigned RW = 4;

    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [5:0]    opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, pc_write, iord, ir_write, mem_write, reg_write;
    logic          reg_dst, memto_reg, alu_src_a, retire, illegal_op;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic [RW-1:0] retired_cnt;

    multicycle_control_fsm #(.RET_W(RW)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
        .iord(iord), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .memto_reg(memto_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .retire(retire), .illegal_op(illegal_op),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_EX, T_AWB, T_BR,
                  T_AE, T_IWB, T_JP, T_RST} tst_t;

    typedef struct packed {
        logic          mem_req, pc_write, iord, ir_write, mem_write, reg_write;
        logic          reg_dst, memto_reg, alu_src_a;
        logic [1:0]    alu_src_b, alu_op, pc_src;
        logic          retire, illegal_op;
        logic [RW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       z;
        logic       mr;
        exp_t       e;
        string      tag;
    } vec_t;

    vec_t          vecs[$];
    vec_t          exp_q[$];
    logic [RW-1:0] m_cnt = '0;
    int            n_vec = 0;
    int            n_fail = 0;

    // Expected control word for a state, straight from the state table.
    function automatic exp_t spec_out(tst_t s, logic [5:0] op, logic z, logic mr);
        exp_t e = '0;
        case (s)
            T_F:   begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            T_D:   begin e.alu_src_b = 2'b11;
                         e.illegal_op = !(op inside {T_LW, T_SW, T_R, T_BEQ, T_ADDI, T_J}); end
            T_MA:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            T_MR:  begin e.mem_req = 1; e.iord = 1; end
            T_MWB: begin e.reg_write = 1; e.memto_reg = 1; e.retire = 1; end
            T_MW:  begin e.mem_req = 1; e.iord = 1; e.mem_write = mr; e.retire = mr; end
            T_EX:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            T_AWB: begin e.reg_write = 1; e.reg_dst = 1; e.retire = 1; end
            T_BR:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
                         e.pc_write = z; e.retire = 1; end
            T_AE:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            T_IWB: begin e.reg_write = 1; e.retire = 1; end
            T_JP:  begin e.pc_src = 2'b10; e.pc_write = 1; e.retire = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic void add(tst_t s, logic [5:0] op, logic z, logic mr, logic rst_n);
        vec_t v;
        if (!rst_n) m_cnt = '0;
        v.rst_n = rst_n; v.op = op; v.z = z; v.mr = mr;
        v.e = spec_out(s, op, z, mr);
        v.e.cnt = m_cnt;
        v.tag = $sformatf("vec%0d_%s_op%b", vecs.size(), s.name(), op);
        if (v.e.retire) m_cnt = m_cnt + RW'(1);
        vecs.push_back(v);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fw stalled fetch cycles, mw stalled memory cycles.
    function automatic void instr(logic [5:0] op, logic z, int fw, int mw);
        for (int i = 0; i < fw; i++) add(T_F, op, rb(), 1'b0, 1'b1);
        add(T_F, op, rb(), 1'b1, 1'b1);
        add(T_D, op, rb(), rb(), 1'b1);
        case (op)
            T_LW: begin
                add(T_MA, op, rb(), rb(), 1'b1);
                for (int i = 0; i < mw; i++) add(T_MR, op, rb(), 1'b0, 1'b1);
                add(T_MR, op, rb(), 1'b1, 1'b1);
                add(T_MWB, op, rb(), rb(), 1'b1);
            end
            T_SW: begin
                add(T_MA, op, rb(), rb(), 1'b1);
                for (int i = 0; i < mw; i++) add(T_MW, op, rb(), 1'b0, 1'b1);
                add(T_MW, op, rb(), 1'b1, 1'b1);
            end
            T_R:    begin add(T_EX, op, rb(), rb(), 1'b1); add(T_AWB, op, rb(), rb(), 1'b1); end
            T_ADDI: begin add(T_AE, op, rb(), rb(), 1'b1); add(T_IWB, op, rb(), rb(), 1'b1); end
            T_BEQ:  add(T_BR, op, z, rb(), 1'b1);
            T_J:    add(T_JP, op, rb(), rb(), 1'b1);
            default: ;
        endcase
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    initial begin
        vec_t v;
        exp_t act;

        add(T_RST, T_LW, 1'b0, 1'b1, 1'b0);
        add(T_RST, T_LW, 1'b0, 1'b1, 1'b0);
        instr(T_LW, 1'b0, 0, 0);
        instr(T_R, 1'b0, 3, 0);
        instr(T_BEQ, 1'b1, 0, 0);
        instr(T_BEQ, 1'b0, 1, 0);
        instr(T_BAD, 1'b0, 0, 0);
        instr(T_ADDI, 1'b0, 0, 0);
        instr(T_J, 1'b0, 0, 0);
        instr(T_SW, 1'b0, 0, 2);
        instr(T_LW, 1'b0, 1, 2);
        for (int k = 0; k < 16; k++) instr(T_R, 1'b0, 0, 0);
        add(T_F, T_SW, 1'b0, 1'b1, 1'b1);
        add(T_D, T_SW, 1'b0, 1'b0, 1'b1);
        add(T_MA, T_SW, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset_n   = vecs[i].rst_n;
            opcode    = vecs[i].op;
            zero      = vecs[i].z;
            mem_ready = vecs[i].mr;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            v = exp_q.pop_front();
            act = {mem_req, pc_write, iord, ir_write, mem_write, reg_write, reg_dst,
                   memto_reg, alu_src_a, alu_src_b, alu_op, pc_src, retire,
                   illegal_op, retired_cnt};
            n_vec++;
            if (act !== v.e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", v.tag, act, v.e);
            end
        end

        // Reset asserted in the middle of a completing store.
        @(posedge clk); #1;
        opcode = T_SW; mem_ready = 1'b1;
        @(negedge clk);
        chk("memwr_strobe_before_reset", 32'(mem_write), 32'd1);
        chk("memwr_retire_before_reset", 32'(retire), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_drops_mem_write", 32'(mem_write), 32'd0);
        chk("reset_drops_mem_req", 32'(mem_req), 32'd0);
        chk("reset_drops_retire", 32'(retire), 32'd0);
        chk("reset_clears_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("post_reset_fetch_req", 32'(mem_req), 32'd1);
        chk("post_reset_fetch_srcb", 32'(alu_src_b), 32'd1);
        chk("post_reset_no_ir_write", 32'(ir_write), 32'd0);
        chk("post_reset_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_fetch_ir_write", 32'(ir_write), 32'd1);
        chk("post_reset_fetch_pc_write", 32'(pc_write), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
